// File: rtl/instr_rom_arb_pkg.sv
// Shared types and helpers for the two-port instruction ROM arbiter.
package instr_rom_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_CORE = 1'b0;
  localparam port_id_t PORT_DBG  = 1'b1;

  localparam int unsigned RomDataW = 32;

  typedef struct packed {
    logic [RomDataW-1:0] data;
    logic                err;
  } rom_rsp_t;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/rom_rsp_skid.sv
// One-deep response hold register with valid/ready and flush; a held word
// takes priority over the live ROM word.
module rom_rsp_skid
  import instr_rom_arb_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     in_valid_i,
  input  rom_rsp_t in_rsp_i,
  input  logic     out_ready_i,
  input  logic     flush_i,
  output logic     out_valid_o,
  output rom_rsp_t out_rsp_o,
  output logic     hold_v_o
);

  logic     hold_v_q, hold_v_d;
  rom_rsp_t hold_q, hold_d;

  always_comb begin
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    if (flush_i) begin
      hold_v_d = 1'b0;
    end else if (hold_v_q) begin
      if (out_ready_i) hold_v_d = 1'b0;
    end else if (in_valid_i && !out_ready_i) begin
      hold_v_d = 1'b1;
      hold_d   = in_rsp_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end

  // Data and error are forced to zero whenever nothing is presented.
  always_comb begin
    out_valid_o = !flush_i && (hold_v_q || in_valid_i);
    out_rsp_o   = '0;
    if (out_valid_o) out_rsp_o = hold_v_q ? hold_q : in_rsp_i;
  end

  assign hold_v_o = hold_v_q;

endmodule

// File: rtl/instr_rom_arbiter.sv
// Arbitrates a single-port, 1-cycle-latency instruction ROM between the core
// fetch unit (priority) and a debug reader with bounded starvation.
module instr_rom_arbiter
  import instr_rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = RomDataW,
  parameter int unsigned ROM_WORDS = 4096,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [1:0][DATA_W-1:0] rsp_data,
  output logic [1:0]             rsp_err,
  input  logic [1:0]             rsp_flush,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_data
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic              inflight_v_q, inflight_v_d;
  port_id_t          inflight_id_q, inflight_id_d;
  logic              inflight_err_q, inflight_err_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  logic [1:0]        inflight_p;
  logic [1:0]        hold_v;
  logic [1:0]        elig;
  logic              force1;
  logic              gnt_v;
  port_id_t          gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_err;
  rom_rsp_t          live_rsp;
  rom_rsp_t          skid_rsp [2];

  // A port with a response outstanding may only issue if it also drains one.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      inflight_p[p] = inflight_v_q && (inflight_id_q == port_id_t'(p));
      elig[p]       = req_valid[p] && ((inflight_p[p] || hold_v[p]) ? rsp_ready[p] : 1'b1);
    end
  end

  always_comb begin
    force1 = (wait_cnt_q == WaitW'(MAX_WAIT));
    gnt_v  = 1'b0;
    gnt_id = PORT_CORE;
    if (force1 && elig[PORT_DBG]) begin
      gnt_v  = 1'b1;
      gnt_id = PORT_DBG;
    end else if (elig[PORT_CORE]) begin
      gnt_v  = 1'b1;
      gnt_id = PORT_CORE;
    end else if (elig[PORT_DBG]) begin
      gnt_v  = 1'b1;
      gnt_id = PORT_DBG;
    end
    req_ready         = '0;
    req_ready[gnt_id] = gnt_v;
  end

  always_comb begin
    gnt_addr = req_addr[gnt_id];
    gnt_err  = (gnt_addr[1:0] != 2'b00) || (word_index(32'(gnt_addr)) >= ROM_WORDS);
    rom_addr = gnt_v ? gnt_addr : last_addr_q;
  end

  always_comb begin
    inflight_v_d   = gnt_v;
    inflight_id_d  = gnt_id;
    inflight_err_d = gnt_err;
    last_addr_d    = rom_addr;
    wait_cnt_d     = wait_cnt_q;
    if (!req_valid[PORT_DBG] || (gnt_v && gnt_id == PORT_DBG)) begin
      wait_cnt_d = '0;
    end else if (elig[PORT_DBG] && gnt_v && gnt_id == PORT_CORE && !force1) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_v_q   <= 1'b0;
      inflight_id_q  <= PORT_CORE;
      inflight_err_q <= 1'b0;
      wait_cnt_q     <= '0;
      last_addr_q    <= '0;
    end else begin
      inflight_v_q   <= inflight_v_d;
      inflight_id_q  <= inflight_id_d;
      inflight_err_q <= inflight_err_d;
      wait_cnt_q     <= wait_cnt_d;
      last_addr_q    <= last_addr_d;
    end
  end

  always_comb begin
    live_rsp.data = inflight_err_q ? '0 : rom_data;
    live_rsp.err  = inflight_err_q;
  end

  for (genvar p = 0; p < 2; p++) begin : g_skid
    rom_rsp_skid u_skid (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (inflight_p[p]),
      .in_rsp_i    (live_rsp),
      .out_ready_i (rsp_ready[p]),
      .flush_i     (rsp_flush[p]),
      .out_valid_o (rsp_valid[p]),
      .out_rsp_o   (skid_rsp[p]),
      .hold_v_o    (hold_v[p])
    );

    assign rsp_data[p] = skid_rsp[p].data;
    assign rsp_err[p]  = skid_rsp[p].err;
  end

endmodule
